// File: rtl/logic_axi4_lite_register_slave.sv
// AXI4-Lite responder terminating into a bank of memory-mapped registers.
// Register contents and per-register write pulses are exported to fabric logic.

module logic_axi4_lite_register_word #(
  parameter int                    DATA_BYTES  = 4,
  parameter logic [DATA_BYTES*8-1:0] RESET_VALUE = '0
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    we,
  input  logic [DATA_BYTES-1:0]   wstrb,
  input  logic [DATA_BYTES*8-1:0] wdata,
  output logic [DATA_BYTES*8-1:0] q
);
  logic [DATA_BYTES*8-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (we) begin
      for (int k = 0; k < DATA_BYTES; k++) begin
        if (wstrb[k]) q_d[k*8 +: 8] = wdata[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) q_q <= RESET_VALUE;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

module logic_axi4_lite_register_slave #(
  parameter int                      DATA_BYTES    = 4,
  parameter int                      ADDRESS_WIDTH = 8,
  parameter int                      REGISTERS     = 16,
  parameter logic [DATA_BYTES*8-1:0] RESET_VALUE   = '0
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              slave_awvalid,
  output logic                              slave_awready,
  input  logic [ADDRESS_WIDTH-1:0]          slave_awaddr,
  input  logic [2:0]                        slave_awprot,
  input  logic                              slave_wvalid,
  output logic                              slave_wready,
  input  logic [DATA_BYTES*8-1:0]           slave_wdata,
  input  logic [DATA_BYTES-1:0]             slave_wstrb,
  output logic                              slave_bvalid,
  input  logic                              slave_bready,
  output logic [1:0]                        slave_bresp,
  input  logic                              slave_arvalid,
  output logic                              slave_arready,
  input  logic [ADDRESS_WIDTH-1:0]          slave_araddr,
  input  logic [2:0]                        slave_arprot,
  output logic                              slave_rvalid,
  input  logic                              slave_rready,
  output logic [DATA_BYTES*8-1:0]           slave_rdata,
  output logic [1:0]                        slave_rresp,
  output logic [REGISTERS*DATA_BYTES*8-1:0] registers,
  output logic [REGISTERS-1:0]              written
);
  localparam int DW    = DATA_BYTES * 8;
  localparam int LSB   = $clog2(DATA_BYTES);
  localparam int IDX_W = ADDRESS_WIDTH - LSB;
  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return 32'(idx) < 32'(REGISTERS);
  endfunction

  logic                 aw_held_q, aw_held_d;
  logic [IDX_W-1:0]     aw_idx_q, aw_idx_d;
  logic                 w_held_q, w_held_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [DATA_BYTES-1:0] wstrb_q, wstrb_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic [REGISTERS-1:0] written_q, written_d;
  logic                 rvalid_q, rvalid_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [DW-1:0]        rdata_q, rdata_d;

  logic [REGISTERS-1:0]         we;
  logic [REGISTERS-1:0][DW-1:0] regs;
  logic                         commit;
  logic [IDX_W-1:0]             ar_idx;
  logic [DW-1:0]                rd_word;
  logic                         unused_ok;

  // A held write may commit on the same edge its predecessor's response is taken.
  assign commit = aw_held_q && w_held_q && (!bvalid_q || slave_bready);
  assign ar_idx = slave_araddr[ADDRESS_WIDTH-1:LSB];

  for (genvar i = 0; i < REGISTERS; i++) begin : g_reg
    assign we[i] = commit && (aw_idx_q == IDX_W'(i));
    logic_axi4_lite_register_word #(
      .DATA_BYTES (DATA_BYTES),
      .RESET_VALUE(RESET_VALUE)
    ) u_word (
      .aclk  (aclk),
      .areset(areset),
      .we    (we[i]),
      .wstrb (wstrb_q),
      .wdata (wdata_q),
      .q     (regs[i])
    );
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (ar_idx == IDX_W'(i)) rd_word = regs[i];
    end
  end

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    written_d = we;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = idx_ok(aw_idx_q) ? OKAY : SLVERR;
    end else if (bvalid_q && slave_bready) begin
      bvalid_d = 1'b0;
    end

    if (slave_awvalid && !aw_held_q) begin
      aw_held_d = 1'b1;
      aw_idx_d  = slave_awaddr[ADDRESS_WIDTH-1:LSB];
    end
    if (slave_wvalid && !w_held_q) begin
      w_held_d = 1'b1;
      wdata_d  = slave_wdata;
      wstrb_d  = slave_wstrb;
    end

    if (slave_arvalid && !rvalid_q) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = idx_ok(ar_idx) ? OKAY : SLVERR;
    end else if (rvalid_q && slave_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      written_q <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      written_q <= written_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign slave_awready = !aw_held_q;
  assign slave_wready  = !w_held_q;
  assign slave_bvalid  = bvalid_q;
  assign slave_bresp   = bresp_q;
  assign slave_arready = !rvalid_q;
  assign slave_rvalid  = rvalid_q;
  assign slave_rdata   = rdata_q;
  assign slave_rresp   = rresp_q;
  assign registers     = regs;
  assign written       = written_q;

  // Protection bits and sub-word address bits carry no meaning here.
  assign unused_ok = ^{slave_awprot, slave_arprot, slave_awaddr, slave_araddr};
endmodule

// File: tb/tb_logic_axi4_lite_register_slave.sv
// Directed bench for logic_axi4_lite_register_slave (4-byte data, 8-bit address, 16 registers).

module tb_logic_axi4_lite_register_slave;
  logic         aclk, areset;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [7:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [511:0] registers;
  logic [15:0]  written;

  logic [15:0][31:0] exp_regs;
  int vectors = 0;
  int errs    = 0;
  logic [1:0]  r_resp;
  logic [15:0] r_wr;
  logic [31:0] r_data;

  logic_axi4_lite_register_slave dut (
    .aclk(aclk), .areset(areset),
    .slave_awvalid(awvalid), .slave_awready(awready), .slave_awaddr(awaddr), .slave_awprot(awprot),
    .slave_wvalid(wvalid), .slave_wready(wready), .slave_wdata(wdata), .slave_wstrb(wstrb),
    .slave_bvalid(bvalid), .slave_bready(bready), .slave_bresp(bresp),
    .slave_arvalid(arvalid), .slave_arready(arready), .slave_araddr(araddr), .slave_arprot(arprot),
    .slave_rvalid(rvalid), .slave_rready(rready), .slave_rdata(rdata), .slave_rresp(rresp),
    .registers(registers), .written(written)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] reg_at(input int i);
    return registers[i*32 +: 32];
  endfunction

  // AW and W together, response accepted as soon as it appears.
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] resp, output logic [15:0] pulse);
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s; bready = 1'b1;
    tick(1);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 20 && !bvalid; i++) tick(1);
    chk("wr_bvalid", 32'(bvalid), 32'd1);
    resp  = bresp;
    pulse = written;
    tick(1);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    arvalid = 1'b1; araddr = a; rready = 1'b0;
    tick(1);
    arvalid = 1'b0;
    for (int i = 0; i < 20 && !rvalid; i++) tick(1);
    chk("rd_rvalid", 32'(rvalid), 32'd1);
    d = rdata; resp = rresp;
    rready = 1'b1;
    tick(1);
    rready = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    awvalid = 0; awaddr = 0; awprot = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
    arvalid = 0; araddr = 0; arprot = 0; rready = 0;
    exp_regs = '0;

    // Reset state
    tick(2);
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready", 32'(wready), 32'd1);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_written", 32'(written), 32'd0);
    chk_vec("rst_regs", registers, exp_regs);
    areset = 1'b0;
    tick(1);

    // Full-word write with latency check, then read back
    awvalid = 1; awaddr = 8'h08; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; bready = 1;
    tick(1);
    awvalid = 0; wvalid = 0;
    chk("t1_awready_held", 32'(awready), 32'd0);
    chk("t1_bvalid_t1", 32'(bvalid), 32'd0);
    tick(1);
    exp_regs[2] = 32'hDEADBEEF;
    chk("t1_bvalid_t2", 32'(bvalid), 32'd1);
    chk("t1_bresp", 32'(bresp), 32'd0);
    chk("t1_written", 32'(written), 32'h0004);
    chk("t1_reg2", reg_at(2), 32'hDEADBEEF);
    tick(1);
    chk("t1_bvalid_clr", 32'(bvalid), 32'd0);
    chk("t1_written_clr", 32'(written), 32'd0);
    arvalid = 1; araddr = 8'h08; rready = 0;
    tick(1);
    arvalid = 0;
    chk("t1_rvalid", 32'(rvalid), 32'd1);
    chk("t1_arready", 32'(arready), 32'd0);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_rresp", 32'(rresp), 32'd0);
    tick(1);
    chk("t1_rdata_stable", rdata, 32'hDEADBEEF);
    rready = 1;
    tick(1);
    rready = 0;
    chk("t1_rvalid_clr", 32'(rvalid), 32'd0);

    // Byte-strobe merge: lanes 0 and 2 replaced
    wr(8'h04, 32'h11223344, 4'hF, r_resp, r_wr);
    wr(8'h04, 32'hAABBCCDD, 4'h5, r_resp, r_wr);
    chk("t2_bresp", 32'(r_resp), 32'd0);
    rd(8'h04, r_data, r_resp);
    chk("t2_rdata", r_data, 32'h11BB33DD);
    exp_regs[1] = 32'h11BB33DD;

    // W five cycles ahead of AW
    wvalid = 1; wdata = 32'hCAFEF00D; wstrb = 4'hF; bready = 1;
    tick(1);
    wvalid = 0;
    chk("t3_wready_low", 32'(wready), 32'd0);
    tick(4);
    chk("t3_no_bvalid", 32'(bvalid), 32'd0);
    chk("t3_no_written", 32'(written), 32'd0);
    chk("t3_reg1_kept", reg_at(1), 32'h11BB33DD);
    awvalid = 1; awaddr = 8'h04;
    tick(1);
    awvalid = 0;
    chk("t3_bvalid_t1", 32'(bvalid), 32'd0);
    tick(1);
    exp_regs[1] = 32'hCAFEF00D;
    chk("t3_bvalid_t2", 32'(bvalid), 32'd1);
    chk("t3_written", 32'(written), 32'h0002);
    chk("t3_reg1", reg_at(1), 32'hCAFEF00D);
    tick(1);
    chk("t3_wready_back", 32'(wready), 32'd1);

    // Out-of-range write/read, top register, zero strobe, unaligned read
    wr(8'h40, 32'hFFFFFFFF, 4'hF, r_resp, r_wr);
    chk("t4_oor_bresp", 32'(r_resp), 32'd2);
    chk("t4_oor_written", 32'(r_wr), 32'd0);
    chk_vec("t4_oor_regs", registers, exp_regs);
    rd(8'h7C, r_data, r_resp);
    chk("t4_oor_rresp", 32'(r_resp), 32'd2);
    chk("t4_oor_rdata", r_data, 32'd0);
    wr(8'h3C, 32'h12345678, 4'hF, r_resp, r_wr);
    exp_regs[15] = 32'h12345678;
    chk("t4_top_bresp", 32'(r_resp), 32'd0);
    chk("t4_top_written", 32'(r_wr), 32'h8000);
    rd(8'h3D, r_data, r_resp);
    chk("t4_unaligned_rdata", r_data, 32'h12345678);
    chk("t4_unaligned_rresp", 32'(r_resp), 32'd0);
    wr(8'h00, 32'hFFFFFFFF, 4'h0, r_resp, r_wr);
    chk("t4_strb0_bresp", 32'(r_resp), 32'd0);
    chk("t4_strb0_written", 32'(r_wr), 32'h0001);
    chk_vec("t4_strb0_regs", registers, exp_regs);

    // Back-pressured response with a second write queued behind it
    bready = 0;
    awvalid = 1; awaddr = 8'h0C; wvalid = 1; wdata = 32'h01010101; wstrb = 4'hF;
    tick(1);
    awvalid = 0; wvalid = 0;
    tick(1);
    exp_regs[3] = 32'h01010101;
    chk("t5_bvalid1", 32'(bvalid), 32'd1);
    chk("t5_written1", 32'(written), 32'h0008);
    awvalid = 1; awaddr = 8'h10; wvalid = 1; wdata = 32'h02020202; wstrb = 4'hF;
    tick(1);
    awvalid = 0; wvalid = 0;
    for (int i = 0; i < 8; i++) begin
      chk("t5_awready_low", 32'(awready), 32'd0);
      chk("t5_wready_low", 32'(wready), 32'd0);
      chk("t5_bresp_hold", 32'(bvalid) << 2 | 32'(bresp), 32'h4);
      chk("t5_reg4_kept", reg_at(4), 32'd0);
      tick(1);
    end
    bready = 1; arvalid = 1; araddr = 8'h10; rready = 0;
    tick(1);
    arvalid = 0;
    exp_regs[4] = 32'h02020202;
    chk("t5_bvalid2", 32'(bvalid), 32'd1);
    chk("t5_written2", 32'(written), 32'h0010);
    chk("t5_reg4", reg_at(4), 32'h02020202);
    chk("t5_rvalid", 32'(rvalid), 32'd1);
    chk("t5_rdata_prewrite", rdata, 32'd0);
    tick(1);
    chk("t5_bvalid_clr", 32'(bvalid), 32'd0);
    rready = 1;
    tick(1);
    rready = 0;
    chk_vec("t5_regs", registers, exp_regs);

    // Reset mid-transaction: read response pending, AW captured without W
    arvalid = 1; araddr = 8'h08; awvalid = 1; awaddr = 8'h00; bready = 1;
    tick(1);
    arvalid = 0; awvalid = 0;
    chk("t6_rvalid_pre", 32'(rvalid), 32'd1);
    chk("t6_awready_pre", 32'(awready), 32'd0);
    #2 areset = 1;
    #1;
    exp_regs = '0;
    chk("t6_rvalid_rst", 32'(rvalid), 32'd0);
    chk("t6_awready_rst", 32'(awready), 32'd1);
    chk_vec("t6_regs_rst", registers, exp_regs);
    tick(1);
    areset = 0;
    wvalid = 1; wdata = 32'h55555555; wstrb = 4'hF;
    tick(1);
    wvalid = 0;
    tick(3);
    chk("t6_no_bvalid", 32'(bvalid), 32'd0);
    chk("t6_no_rvalid", 32'(rvalid), 32'd0);
    chk("t6_no_written", 32'(written), 32'd0);
    chk_vec("t6_regs_after", registers, exp_regs);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
